// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: loader FSM state
// encoding, the default frame header byte and the baud divider helper.
package loader_pkg;

    // Loader FSM state encoding (3 bits)
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_HDR = 3'd1;
    localparam logic [2:0] ST_GET_CNT  = 3'd2;
    localparam logic [2:0] ST_GET_DATA = 3'd3;
    localparam logic [2:0] ST_GET_SUM  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_ERROR    = 3'd6;

    // Frame start byte used unless the top is told otherwise
    localparam logic [7:0] DEFAULT_HDR = 8'hA5;

    // Clock cycles per serial bit, truncated; callers need a result >= 8
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit glitch rejection at
// half a bit, mid-bit sampling, one-cycle byte / framing-error pulses.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iRXD,
    output logic [7:0] oBYTE,
    output logic       oVALID,
    output logic       oFERR
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    logic             rx_s1, rx_s2, rx_prev;
    logic [2:0]       rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Synchronise the raw line and keep the previous synced value for edge detection
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= iRXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Bit-timing state machine: start check, 8 data bits LSB-first, stop bit
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            oBYTE    <= '0;
            oVALID   <= 1'b0;
            oFERR    <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            oFERR  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    // A line already back high at mid start bit is a glitch
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == DIV_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == DIV_M1) begin
                        cnt <= '0;
                        if (rx_s2) begin
                            oBYTE    <= shreg;
                            oVALID   <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            oFERR    <= 1'b1;
                            rx_state <= RX_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    // Re-arm only once the line has returned to idle
                    if (rx_s2) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: parses HDR, word count N (0 = 256), N big-endian
// 32-bit words and an XOR checksum, writes each word to instruction RAM and
// holds the CPU until a frame has loaded with a good checksum.
// ADDR_W must be at least 8 so that a 256-word frame fits.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int         CLK_HZ = 50000000,
    parameter int         BAUD   = 115200,
    parameter int         ADDR_W = 8,
    parameter logic [7:0] HDR    = DEFAULT_HDR
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRXD,
    input  logic              iLOAD_EN,
    output logic              oWE,
    output logic [ADDR_W-1:0] oADDR,
    output logic [31:0]       oDATA,
    output logic              oCPU_HOLD,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR,
    output logic [ADDR_W:0]   oWORD_CNT
);
    localparam int CNT_W = ADDR_W + 1;

    logic [7:0]       rx_byte;
    logic             rx_valid, rx_ferr;
    logic [2:0]       state;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      word_sh;
    logic [7:0]       acc;
    logic [1:0]       byte_idx;
    logic             we_q;
    logic             in_frame;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iRXD   (iRXD),
        .oBYTE  (rx_byte),
        .oVALID (rx_valid),
        .oFERR  (rx_ferr)
    );

    // A write due in the same cycle that load enable drops is suppressed
    assign oWE       = we_q & iLOAD_EN;
    assign oCPU_HOLD = (state != ST_IDLE) && (state != ST_DONE);
    assign oBUSY     = (state == ST_GET_CNT) || (state == ST_GET_DATA) || (state == ST_GET_SUM);
    assign in_frame  = (state == ST_WAIT_HDR) || oBUSY;
    assign cnt_next  = oWORD_CNT + 1'b1;

    // Loader FSM, word assembler, checksum and word counter
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_IDLE;
            n_words   <= '0;
            word_sh   <= '0;
            acc       <= '0;
            byte_idx  <= '0;
            we_q      <= 1'b0;
            oADDR     <= '0;
            oDATA     <= '0;
            oDONE     <= 1'b0;
            oERR      <= 1'b0;
            oWORD_CNT <= '0;
        end else begin
            we_q <= 1'b0;
            if (!iLOAD_EN) begin
                // Abort: partial word dropped, sticky flags and count kept
                state <= ST_IDLE;
            end else if (rx_ferr && in_frame) begin
                state <= ST_ERROR;
                oERR  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_WAIT_HDR;
                        oDONE     <= 1'b0;
                        oERR      <= 1'b0;
                        oWORD_CNT <= '0;
                    end
                    ST_WAIT_HDR: begin
                        if (rx_valid && rx_byte == HDR) state <= ST_GET_CNT;
                    end
                    ST_GET_CNT: begin
                        if (rx_valid) begin
                            n_words  <= (rx_byte == 8'd0) ? CNT_W'(256) : CNT_W'(rx_byte);
                            acc      <= '0;
                            byte_idx <= '0;
                            state    <= ST_GET_DATA;
                        end
                    end
                    ST_GET_DATA: begin
                        if (we_q) begin
                            oWORD_CNT <= cnt_next;
                            if (cnt_next == n_words) state <= ST_GET_SUM;
                        end
                        if (rx_valid) begin
                            word_sh  <= {word_sh[23:0], rx_byte};
                            acc      <= acc ^ rx_byte;
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == 2'd3) begin
                                we_q  <= 1'b1;
                                oADDR <= oWORD_CNT[ADDR_W-1:0];
                                oDATA <= {word_sh[23:0], rx_byte};
                            end
                        end
                    end
                    ST_GET_SUM: begin
                        if (rx_valid) begin
                            if (rx_byte == acc) begin
                                state <= ST_DONE;
                                oDONE <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                oERR  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        // Held until load enable drops
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at DIV=8 (CLK_HZ=800, BAUD=100),
// the smallest legal divider, so the 256-word image stays short.
module tb_uart_prog_loader;
    localparam int CLK_HZ = 800;
    localparam int BAUD   = 100;
    localparam int DIV    = 8;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rxd = 1'b1;
    logic              load_en = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              cpu_hold, busy, done, err;
    logic [ADDR_W:0]   word_cnt;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int base;
    logic [7:0]  log_addr [0:511];
    logic [31:0] log_data [0:511];

    uart_prog_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W),
        .HDR    (8'hA5)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iRXD      (rxd),
        .iLOAD_EN  (load_en),
        .oWE       (we),
        .oADDR     (addr),
        .oDATA     (data),
        .oCPU_HOLD (cpu_hold),
        .oBUSY     (busy),
        .oDONE     (done),
        .oERR      (err),
        .oWORD_CNT (word_cnt)
    );

    always #5 clk = ~clk;

    // Log every write strobe cycle, sampled on the inactive edge
    always @(negedge clk) begin
        if (we) begin
            if (we_cnt < 512) begin
                log_addr[we_cnt] <= addr;
                log_data[we_cnt] <= data;
            end
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stopv;
        tick(DIV);
        rxd = 1'b1;
        if (!stopv) tick(4);
    endtask

    task automatic send_seq(input logic [7:0] b [], input int n);
        for (int i = 0; i < n; i++) send_byte(b[i], 1'b1);
    endtask

    task automatic start_load();
        load_en = 1'b1;
        tick(2);
        base = we_cnt;
    endtask

    task automatic end_load();
        load_en = 1'b0;
        tick(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] f_ok   [] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        logic [7:0] f_bad  [] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        logic [7:0] f_junk [] = '{8'h00, 8'hFF, 8'h3C};
        logic [7:0] f_dead [] = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        logic [7:0] f_two  [] = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] f_cafe [] = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
        logic [7:0] kb;

        // Reset state
        tick(3);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wcnt", 64'(word_cnt), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single word with good checksum
        start_load();
        chk("wait_hold", 64'(cpu_hold), 64'd1);
        chk("wait_busy", 64'(busy), 64'd0);
        send_seq(f_ok, 7);
        tick(4);
        chk("one_we_cnt", 64'(we_cnt - base), 64'd1);
        chk("one_addr", 64'(log_addr[base]), 64'd0);
        chk("one_data", 64'(log_data[base]), 64'h12345678);
        chk("one_done", 64'(done), 64'd1);
        chk("one_hold", 64'(cpu_hold), 64'd0);
        chk("one_busy", 64'(busy), 64'd0);
        chk("one_wcnt", 64'(word_cnt), 64'd1);
        chk("one_err", 64'(err), 64'd0);
        end_load();
        chk("one_done_kept", 64'(done), 64'd1);

        // Bad checksum
        start_load();
        chk("bad_done_clr", 64'(done), 64'd0);
        send_seq(f_bad, 7);
        tick(4);
        chk("bad_we_cnt", 64'(we_cnt - base), 64'd1);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_done", 64'(done), 64'd0);
        tick(50);
        chk("bad_hold", 64'(cpu_hold), 64'd1);
        end_load();
        chk("bad_hold_rel", 64'(cpu_hold), 64'd0);
        chk("bad_err_kept", 64'(err), 64'd1);

        // Garbage bytes and a short glitch before the header
        start_load();
        chk("junk_err_clr", 64'(err), 64'd0);
        send_seq(f_junk, 3);
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(20);
        chk("junk_busy", 64'(busy), 64'd0);
        chk("junk_hold", 64'(cpu_hold), 64'd1);
        chk("junk_we", 64'(we_cnt - base), 64'd0);
        send_seq(f_dead, 7);
        tick(4);
        chk("junk_done", 64'(done), 64'd1);
        chk("junk_we_cnt", 64'(we_cnt - base), 64'd1);
        chk("junk_data", 64'(log_data[base]), 64'hDEADBEEF);
        end_load();

        // Framing error on the 3rd data byte
        start_load();
        send_seq(f_ok, 4);
        send_byte(8'h56, 1'b0);
        tick(4);
        chk("ferr_err", 64'(err), 64'd1);
        chk("ferr_hold", 64'(cpu_hold), 64'd1);
        chk("ferr_busy", 64'(busy), 64'd0);
        chk("ferr_we", 64'(we_cnt - base), 64'd0);
        end_load();

        // Full 256-word image, word k = {4{k}}, checksum 00
        start_load();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            for (int j = 0; j < 4; j++) send_byte(kb, 1'b1);
        end
        send_byte(8'h00, 1'b1);
        tick(4);
        chk("full_we_cnt", 64'(we_cnt - base), 64'd256);
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            chk("full_addr", 64'(log_addr[base + k]), 64'(kb));
            chk("full_data", 64'(log_data[base + k]), 64'({4{kb}}));
        end
        chk("full_wcnt", 64'(word_cnt), 64'd256);
        chk("full_done", 64'(done), 64'd1);
        chk("full_err", 64'(err), 64'd0);
        end_load();

        // Abort after two bytes of word 1
        start_load();
        send_seq(f_two, 8);
        tick(2);
        chk("abort_we_pre", 64'(we_cnt - base), 64'd1);
        chk("abort_busy_pre", 64'(busy), 64'd1);
        load_en = 1'b0;
        tick(2);
        chk("abort_hold", 64'(cpu_hold), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_wcnt", 64'(word_cnt), 64'd1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        tick(4);
        chk("abort_we_post", 64'(we_cnt - base), 64'd1);

        // Asynchronous reset in the middle of a byte
        start_load();
        send_seq(f_two, 7);
        rxd = 1'b0;
        tick(DIV);
        rxd = 1'b1;
        tick(DIV + 3);
        chk("mid_hold_pre", 64'(cpu_hold), 64'd1);
        #2;
        rst_n = 1'b0;
        rxd   = 1'b1;
        #1;
        chk("arst_we", 64'(we), 64'd0);
        chk("arst_addr", 64'(addr), 64'd0);
        chk("arst_data", 64'(data), 64'd0);
        chk("arst_hold", 64'(cpu_hold), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_wcnt", 64'(word_cnt), 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        base = we_cnt;
        send_seq(f_cafe, 7);
        tick(4);
        chk("rec_done", 64'(done), 64'd1);
        chk("rec_we_cnt", 64'(we_cnt - base), 64'd1);
        chk("rec_data", 64'(log_data[base]), 64'hCAFEBABE);
        end_load();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
